// File: rtl/r_instr_encoder.sv
// r_instr_encoder
//   Streaming MIPS R-type encoder. Requests {alu_op, rs, rt, rd} are encoded
//   combinationally, buffered in a FIFO and drained into instruction memory
//   through a stallable write port, one word per cycle.
//
//   Optional feature: define R_ENC_NOP_PAD_EN to follow every instruction
//   write with a NOP write (all-zero word) at the next address.
//
// Ports
//   clk, rst            clock, async active-high reset
//   clear               sync flush: FIFO empty, address reload, count zero
//   in_valid/in_ready   request handshake (in_ready = !full)
//   alu_op, rs, rt, rd  request fields
//   mem_we/addr/data    memory write port, held while mem_busy
//   mem_busy            memory stall
//   wr_count            completed writes, saturating
//   empty               FIFO empty and no write pending
module r_instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_busy,
  output logic [ADDR_W:0]   wr_count,
  output logic              empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE
`ifdef R_ENC_NOP_PAD_EN
    , S_PAD
`endif
  } state_t;

  state_t state, state_n;

  // ---------------- encoder ----------------
  logic [5:0]  func;
  logic [31:0] enc_word;

  always_comb begin
    func = 6'b100000;
    case (alu_op)
      3'b100: func = 6'b100000;
      3'b101: func = 6'b100010;
      3'b000: func = 6'b100100;
      3'b001: func = 6'b100101;
      3'b010: func = 6'b100110;
      3'b011: func = 6'b100111;
      3'b110: func = 6'b101011;
      3'b111: func = 6'b000100;
      default: func = 6'b100000;
    endcase
  end

  assign enc_word = {6'b000000, rs, rt, rd, 5'b00000, func};

  // ---------------- FIFO ----------------
  // Pointers carry one wrap bit so full/empty are distinguishable.
  logic [31:0] fifo_q [FIFO_DEPTH];
  logic [PW:0] wptr, rptr;
  logic        full, fifo_empty, push, pop;

  assign fifo_empty = (wptr == rptr);
  assign full       = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  // Fullness is from registered pointers: a pop this cycle does not free a slot.
  assign in_ready   = !full;
  assign push       = in_valid && !full && !clear;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr[PW-1:0]] <= enc_word;
  end

  // ---------------- drain FSM ----------------
  logic done;
`ifdef R_ENC_NOP_PAD_EN
  logic load_nop;
`endif

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    done    = 1'b0;
`ifdef R_ENC_NOP_PAD_EN
    load_nop = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!mem_busy) begin
          done = 1'b1;
`ifdef R_ENC_NOP_PAD_EN
          load_nop = 1'b1;
          state_n  = S_PAD;
`else
          if (!fifo_empty) pop = 1'b1;
          else             state_n = S_IDLE;
`endif
        end
      end
`ifdef R_ENC_NOP_PAD_EN
      S_PAD: begin
        if (!mem_busy) begin
          done = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = S_WRITE;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
    // clear abandons any held write and blocks the drain this cycle
    if (clear) begin
      state_n = S_IDLE;
      pop     = 1'b0;
      done    = 1'b0;
`ifdef R_ENC_NOP_PAD_EN
      load_nop = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      mem_addr <= BASE;
      mem_data <= '0;
      wr_count <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        wptr     <= '0;
        rptr     <= '0;
        mem_addr <= BASE;
        wr_count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) begin
          rptr     <= rptr + 1'b1;
          mem_data <= fifo_q[rptr[PW-1:0]];
        end
`ifdef R_ENC_NOP_PAD_EN
        if (load_nop) mem_data <= 32'h0000_0000;
`endif
        // mem_addr always points at the address of the pending/next write
        if (done) begin
          mem_addr <= mem_addr + 1'b1;
          if (wr_count != '1) wr_count <= wr_count + 1'b1;
        end
      end
    end
  end

  // Driven straight from the state register so rst drops it asynchronously.
  assign mem_we = (state != S_IDLE);
  assign empty  = fifo_empty && (state == S_IDLE);

endmodule

// File: tb/tb_r_instr_encoder.sv
// tb_r_instr_encoder
//   Directed, table-driven bench for r_instr_encoder. A negedge monitor logs
//   every completed write (address, data); expected writes are built from the
//   vector table and compared in order. A second instance with ADDR_W=2
//   covers address wrap and wr_count saturation.
module tb_r_instr_encoder;

`ifdef R_ENC_NOP_PAD_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0, in_valid = 1'b0, mem_busy = 1'b0;
  logic [2:0]  alu_op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic        in_ready, mem_we, empty;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [8:0]  wr_count;

  logic        s_clear = 1'b0, s_valid = 1'b0, s_busy = 1'b0;
  logic        s_ready, s_we, s_empty;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  logic [2:0]  s_count;

  always #5 clk = ~clk;

  r_instr_encoder u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rs(rs), .rt(rt), .rd(rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_busy(mem_busy),
    .wr_count(wr_count), .empty(empty)
  );

  r_instr_encoder #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_valid), .in_ready(s_ready),
    .alu_op(alu_op), .rs(rs), .rt(rt), .rd(rd),
    .mem_we(s_we), .mem_addr(s_addr), .mem_data(s_data), .mem_busy(s_busy),
    .wr_count(s_count), .empty(s_empty)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] word;
  } vec_t;

  vec_t tbl [10];

  int n_vec = 0, n_bad = 0;
  logic [31:0] got_a [2][$], got_d [2][$], exp_a [2][$], exp_d [2][$];
  int nxt [2] = '{0, 0};

  // write completes at the coming edge if we && !busy (and no clear/reset)
  always @(negedge clk) begin
    if (!rst && !clear && mem_we && !mem_busy) begin
      got_a[0].push_back(32'(mem_addr)); got_d[0].push_back(mem_data);
    end
    if (!rst && !s_clear && s_we && !s_busy) begin
      got_a[1].push_back(32'(s_addr)); got_d[1].push_back(s_data);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_instr(input int inst, input logic [31:0] w);
    int m;
    m = (inst == 0) ? 255 : 3;
    exp_a[inst].push_back(32'(nxt[inst] & m)); exp_d[inst].push_back(w); nxt[inst]++;
`ifdef R_ENC_NOP_PAD_EN
    exp_a[inst].push_back(32'(nxt[inst] & m)); exp_d[inst].push_back(32'h0); nxt[inst]++;
`endif
  endtask

  task automatic flush_log(input int inst);
    got_a[inst].delete(); got_d[inst].delete();
    exp_a[inst].delete(); exp_d[inst].delete();
    nxt[inst] = 0;
  endtask

  task automatic send(input int inst, input int idx);
    bit ok;
    ok = 1'b0;
    alu_op = tbl[idx].op; rs = tbl[idx].rs; rt = tbl[idx].rt; rd = tbl[idx].rd;
    if (inst == 0) in_valid = 1'b1; else s_valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = (inst == 0) ? in_ready : s_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0; s_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
    if (ok) expect_instr(inst, tbl[idx].word);
  endtask

  task automatic wait_empty(input int inst);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = (inst == 0) ? empty : s_empty;
    end
    @(posedge clk); #1;
    check("drain_done", 32'(ok), 32'd1);
  endtask

  task automatic compare_log(input int inst, input string nm);
    check({nm, "_nwrites"}, 32'(got_a[inst].size()), 32'(exp_a[inst].size()));
    for (int i = 0; i < exp_a[inst].size() && i < got_a[inst].size(); i++) begin
      check($sformatf("%s_addr%0d", nm, i), got_a[inst][i], exp_a[inst][i]);
      check($sformatf("%s_data%0d", nm, i), got_d[inst][i], exp_d[inst][i]);
    end
  endtask

  task automatic do_clear;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    flush_log(0);
  endtask

  initial begin
    // {op, rs, rt, rd, expected word}
    tbl[0] = '{3'b100, 5'd1,  5'd2,  5'd3,  32'h0022_1820};
    tbl[1] = '{3'b101, 5'd0,  5'd0,  5'd0,  32'h0000_0022};
    tbl[2] = '{3'b000, 5'd0,  5'd0,  5'd0,  32'h0000_0024};
    tbl[3] = '{3'b001, 5'd0,  5'd0,  5'd0,  32'h0000_0025};
    tbl[4] = '{3'b010, 5'd0,  5'd0,  5'd0,  32'h0000_0026};
    tbl[5] = '{3'b011, 5'd0,  5'd0,  5'd0,  32'h0000_0027};
    tbl[6] = '{3'b110, 5'd0,  5'd0,  5'd0,  32'h0000_002B};
    tbl[7] = '{3'b111, 5'd0,  5'd0,  5'd0,  32'h0000_0004};
    tbl[8] = '{3'b111, 5'd31, 5'd31, 5'd31, 32'h03FF_F804};
    tbl[9] = '{3'b010, 5'd5,  5'd10, 5'd17, 32'h00AA_8826};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", mem_data,      32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_s_addr",   32'(s_addr),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single request: latency and first write
    send(0, 0);
    @(negedge clk);
    check("lat_we_edgeN",  32'(mem_we), 32'd0);
    check("lat_empty_N",   32'(empty),  32'd0);
    @(negedge clk);
    check("lat_we_edgeN1", 32'(mem_we), 32'd1);
    check("lat_data_N1",   mem_data,    32'h0022_1820);
    check("lat_addr_N1",   32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    wait_empty(0);
    compare_log(0, "single");
    check("single_wr_count", 32'(wr_count), 32'(K));
    check("single_empty",    32'(empty),    32'd1);

    // whole table, back to back
    do_clear();
    for (int i = 0; i < 10; i++) send(0, i);
    wait_empty(0);
    compare_log(0, "table");
    check("table_wr_count", 32'(wr_count), 32'(10 * K));

    // stall: 1 held at output + 4 in FIFO, then in_ready drops
    do_clear();
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) send(0, i);
    @(negedge clk);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    check("busy_we",       32'(mem_we),   32'd1);
    check("busy_addr",     32'(mem_addr), 32'd0);
    check("busy_data",     mem_data,      tbl[0].word);
    check("busy_count",    32'(wr_count), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("busy_addr_hold", 32'(mem_addr), 32'd0);
    check("busy_data_hold", mem_data,      tbl[0].word);
    check("busy_we_hold",   32'(mem_we),   32'd1);
    @(posedge clk); #1;
    mem_busy = 1'b0;
    wait_empty(0);
    compare_log(0, "busy");
    check("busy_wr_count", 32'(wr_count), 32'(5 * K));

    // clear mid-stream, with a request offered in the same cycle
    mem_busy = 1'b1;
    for (int i = 5; i < 8; i++) send(0, i);
    alu_op = tbl[8].op; rs = tbl[8].rs; rt = tbl[8].rt; rd = tbl[8].rd;
    in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr_we",       32'(mem_we),   32'd0);
    check("clr_empty",    32'(empty),    32'd1);
    check("clr_wr_count", 32'(wr_count), 32'd0);
    check("clr_addr",     32'(mem_addr), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    flush_log(0);
    mem_busy = 1'b0;
    send(0, 9);
    wait_empty(0);
    compare_log(0, "after_clr");
    check("after_clr_count", 32'(wr_count), 32'(K));

    // ADDR_W=2: address wrap and wr_count saturation at 7
    for (int i = 0; i < 5; i++) send(1, i);
    wait_empty(1);
    compare_log(1, "wrap");
    check("wrap_count", 32'(s_count), 32'((5 * K > 7) ? 7 : 5 * K));
    for (int i = 5; i < 9; i++) send(1, i);
    wait_empty(1);
    compare_log(1, "wrap2");
    check("sat_count", 32'(s_count), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/r_instr_encoder.md
# r_instr_encoder

Streaming R-type instruction encoder: the inverse of the opcode/func decoder in the execution path. It accepts an ALU operation code plus register fields over a valid/ready handshake and builds 32-bit MIPS R-type words. Words are buffered in a small FIFO and written one per cycle into instruction memory through a stallable write port. It lets self-test and bring-up logic generate programs for the core without a software toolchain.

## Interface
- `FIFO_DEPTH`, default 4: encoded-word buffer depth; power of two, ≥2.
- `ADDR_W`, default 8: instruction memory word-address width.
- `BASE_ADDR`, default 0: first write address after reset or `clear`.
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous; empties the FIFO, reloads the address, zeroes the count and drops `mem_we`.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: request accepted when `in_valid && in_ready`.
- `alu_op`  in  3: ALU operation to encode.
- `rs`, `rt`, `rd`  in  5 each: register fields.
- `mem_we`  out  1: memory write request.
- `mem_addr`  out  `ADDR_W`: word address.
- `mem_data`  out  32: instruction word.
- `mem_busy`  in  1: memory stall.
- `wr_count`  out  `ADDR_W+1`: completed writes since reset/clear; saturates at all-ones.
- `empty`  out  1: FIFO empty and no write pending.

## Operation
- Word format is `{6'b000000, rs, rt, rd, 5'b00000, func}`. The opcode and shamt fields are always zero.
- `alu_op` to func mapping:
  - 100 → 100000 (add)
  - 101 → 100010 (sub)
  - 000 → 100100 (and)
  - 001 → 100101 (or)
  - 010 → 100110 (xor)
  - 011 → 100111 (nor)
  - 110 → 101011 (sltu)
  - 111 → 000100 (sllv)
  - All eight codes are legal; there is no error path.
- Encoding is combinational at the input. The encoded word is written into the FIFO on the accepting edge.
- `in_ready = !full`. Fullness comes from registered pointers, so a pop in the same cycle does not admit a push into a full FIFO.
- Drain FSM states:
  - **IDLE**: `mem_we=0`. If the FIFO is non-empty, pop the head into the output registers, set `mem_we=1`, go to **WRITE**.
  - **WRITE**: `mem_we`, `mem_addr` and `mem_data` are held stable while `mem_busy=1`. The write completes on an edge with `mem_busy=0`. On completion: `mem_addr` increments (wraps modulo 2^`ADDR_W`, back past `BASE_ADDR`), `wr_count` increments. Next state:
    - **PAD** if padding is compiled in;
    - otherwise, if the FIFO is non-empty, pop the next word and stay in **WRITE** (back-to-back, one write per cycle);
    - otherwise **IDLE**.
  - **PAD** (macro only): `mem_data=32'h0000_0000` (NOP) at the next address. Same stall and completion rules as **WRITE**, then go to **WRITE** or **IDLE** as above.
- Simultaneous push and pop on a non-full, non-empty FIFO is legal; occupancy is unchanged.
- `clear` has priority over every handshake in the same cycle, and the input is not accepted that cycle. An in-flight held write is abandoned.
- `rst` mid-write: everything returns to reset values immediately; the memory sees `mem_we` fall asynchronously.

## Timing
- Reset values:
  - `in_ready=1`, `mem_we=0`, `mem_addr=BASE_ADDR`, `mem_data=0`, `wr_count=0`, `empty=1`
  - FSM in IDLE, FIFO empty.
- Latency from an accept at edge N (empty FIFO, IDLE, no stall): `mem_we=1` with the word from edge N+1; the write completes at edge N+2.
- Throughput without padding: 1 word/cycle sustained. With padding: 1 instruction per 2 cycles.
- `empty` goes high the cycle after the last write completes with the FIFO empty.

## Configuration
- `R_ENC_NOP_PAD_EN` defined: a NOP write (PAD state) follows every instruction write. It is counted in `wr_count` and consumes one address.
- Undefined: the PAD state and its logic are absent; only instruction words are written.

## Test plan
- Reset, then one request `alu_op=100, rs=1, rt=2, rd=3` → one write, `mem_addr=0`, `mem_data=32'h0022_1820`, `wr_count=1`, `empty=1` after.
- All eight `alu_op` codes with `rs=rt=rd=0` → funcs 20, 22, 24, 25, 26, 27, 2B, 04 (hex) on `mem_data`, addresses 0..7.
- Hold `mem_busy=1` while pushing 5 requests → `in_ready` falls after the FIFO holds 4 plus 1 word is held at the output. Address and data are stable throughout; releasing `mem_busy` drains in order with no loss.
- `ADDR_W=2`, 5 writes → addresses 0, 1, 2, 3, 0; `wr_count=5`.
- Assert `clear` mid-stream with 3 words queued → the next cycle has `mem_we=0`, `empty=1`, `wr_count=0`, `mem_addr=BASE_ADDR`; a subsequent request writes at `BASE_ADDR`.
- With `R_ENC_NOP_PAD_EN`, two requests → writes `instr0@0`, `NOP@1`, `instr1@2`, `NOP@3`; `wr_count=4`.
